// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared constants and types for the serial pattern detector.
//   - Default MAX_LEN / CNT_W / TMO_W sizes.
//   - FSM state encodings (IDLE / ARMED / DONE).
//   - seq_desc_t: packed descriptor at default sizes, for CSR-side agents.
// Optional build macro: SEQ_DETECT_CTRL_AUTO_REARM_EN (used in seq_detect_ctrl).
package seq_detect_pkg;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;
    localparam int TMO_W_DEF   = 16;
    localparam int LEN_W_DEF   = $clog2(MAX_LEN_DEF + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef struct packed {
        logic [MAX_LEN_DEF-1:0] pattern;
        logic [LEN_W_DEF-1:0]   len;
        logic [CNT_W_DEF-1:0]   hits;
        logic [TMO_W_DEF-1:0]   timeout;
    } seq_desc_t;

endpackage

// File: rtl/seq_match_window.sv
// seq_match_window: serial shift window with warm-up tracking and masked compare.
//   clk, reset     : clock, synchronous active-high reset
//   clear_i        : synchronous clear of shift register and valid-bit counter
//   din_valid_i    : qualifies din_i (shift enable)
//   din_i          : serial bit, shifted into bit 0
//   pattern_i      : pattern, bit 0 = most recent bit
//   len_i          : active pattern length (1..MAX_LEN)
//   match_o        : combinational, 1 when the window including din_i matches
module seq_match_window
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear_i,
    input  logic               din_valid_i,
    input  logic               din_i,
    input  logic [MAX_LEN-1:0] pattern_i,
    input  logic [LEN_W-1:0]   len_i,
    output logic               match_o
);

    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [MAX_LEN-1:0] mask;

    always_comb begin
        sr_d  = {sr_q[MAX_LEN-2:0], din_i};
        // Bit count saturates at MAX_LEN; enough to know the window is full.
        cnt_d = (cnt_q == LEN_W'(MAX_LEN)) ? cnt_q : cnt_q + 1'b1;
        mask  = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LEN_W'(i) < len_i);
        end
        // Compare against the window as it will be after this bit shifts in,
        // but only once len bits have arrived since the last clear.
        match_o = din_valid_i && (cnt_d >= len_i) &&
                  (((sr_d ^ pattern_i) & mask) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (din_valid_i) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: configure / arm / sequence a programmable serial pattern detector.
//   clk, reset          : clock, synchronous active-high reset
//   cfg_valid/cfg_ready : descriptor handshake (ready only in IDLE)
//   cfg_pattern/len/hits/timeout : descriptor fields
//   cfg_err             : one-cycle pulse when a descriptor with bad length is offered
//   din_valid, din      : qualified serial stream
//   abort               : cancel an armed run (back to IDLE, no done)
//   ack                 : acknowledge done
//   seen                : one-cycle pulse per match
//   hit_count           : matches in current run, saturating
//   busy / done         : in ARMED / in DONE
//   timed_out           : while done, 1 = run ended by timeout
// Optional build macro: SEQ_DETECT_CTRL_AUTO_REARM_EN -- a hit-terminated run
// shows done for one cycle, then re-arms with the same descriptor.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TMO_W   = TMO_W_DEF,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [CNT_W-1:0]   cfg_hits,
    input  logic [TMO_W-1:0]   cfg_timeout,
    output logic               cfg_err,
    input  logic               din_valid,
    input  logic               din,
    input  logic               abort,
    input  logic               ack,
    output logic               seen,
    output logic [CNT_W-1:0]   hit_count,
    output logic               busy,
    output logic               done,
    output logic               timed_out
);

    typedef struct packed {
        logic [MAX_LEN-1:0] pattern;
        logic [LEN_W-1:0]   len;
        logic [CNT_W-1:0]   hits;
        logic [TMO_W-1:0]   timeout;
    } desc_t;

    logic [1:0]       state_q, state_d;
    desc_t            desc_q, desc_d;
    logic [CNT_W-1:0] hit_q, hit_d, hit_inc;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic             seen_q, seen_d;
    logic             to_q, to_d;
    logic             err_q, err_d;
    logic             len_ok, load, rearm, match;

    assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign load   = (state_q == ST_IDLE) && cfg_valid && len_ok;

`ifdef SEQ_DETECT_CTRL_AUTO_REARM_EN
    // Hit-terminated runs leave DONE after one cycle; timeouts still wait for ack.
    assign rearm = (state_q == ST_DONE) && !to_q;
`else
    assign rearm = 1'b0;
`endif

    seq_match_window #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_win (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (load || rearm),
        .din_valid_i (din_valid && (state_q == ST_ARMED)),
        .din_i       (din),
        .pattern_i   (desc_q.pattern),
        .len_i       (desc_q.len),
        .match_o     (match)
    );

    assign hit_inc = (&hit_q) ? hit_q : hit_q + 1'b1;
    assign tmo_inc = tmo_q + 1'b1;

    always_comb begin
        state_d = state_q;
        desc_d  = desc_q;
        hit_d   = hit_q;
        tmo_d   = tmo_q;
        seen_d  = 1'b0;
        to_d    = to_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_valid) begin
                    if (len_ok) begin
                        desc_d  = '{pattern: cfg_pattern, len: cfg_len,
                                    hits: cfg_hits, timeout: cfg_timeout};
                        hit_d   = '0;
                        tmo_d   = '0;
                        to_d    = 1'b0;
                        state_d = ST_ARMED;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_inc;
                    if (match) begin
                        seen_d = 1'b1;
                        hit_d  = hit_inc;
                    end
                    // The final hit outranks a timeout landing on the same cycle.
                    if (match && (desc_q.hits != '0) && (hit_inc == desc_q.hits)) begin
                        state_d = ST_DONE;
                        to_d    = 1'b0;
                    end else if ((desc_q.timeout != '0) && (tmo_inc == desc_q.timeout)) begin
                        state_d = ST_DONE;
                        to_d    = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (rearm) begin
                    state_d = ST_ARMED;
                    hit_d   = '0;
                    tmo_d   = '0;
                end else if (ack) begin
                    state_d = ST_IDLE;
                    to_d    = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            desc_q  <= '0;
            hit_q   <= '0;
            tmo_q   <= '0;
            seen_q  <= 1'b0;
            to_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            desc_q  <= desc_d;
            hit_q   <= hit_d;
            tmo_q   <= tmo_d;
            seen_q  <= seen_d;
            to_q    <= to_d;
            err_q   <= err_d;
        end
    end

    assign cfg_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_ARMED);
    assign done      = (state_q == ST_DONE);
    assign seen      = seen_q;
    assign hit_count = hit_q;
    assign timed_out = to_q;
    assign cfg_err   = err_q;

endmodule
